// File: rtl/fft_frame_pkg.sv
// Shared types and sizes for the FFT frame assembler.
package fft_frame_pkg;

  localparam int NPT    = 16;
  localparam int HALF_W = 16;
  localparam int SMP_W  = 2 * HALF_W;
  localparam int IDX_W  = 4;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

endpackage

// File: rtl/frame_idx_map.sv
// Maps a 4-bit position within the frame to the bin index it is stored at.
// Optional feature macro: FFT_FRAME_BITREV_EN (bit-reversed mapping for
// radix-2 FFT output order); undefined gives natural order.
module frame_idx_map
  import fft_frame_pkg::*;
(
  input  logic [IDX_W-1:0] i_pos,
  output logic [IDX_W-1:0] o_bin
);

`ifdef FFT_FRAME_BITREV_EN
  // Reverse the bit order of the position.
  assign o_bin = {i_pos[0], i_pos[1], i_pos[2], i_pos[3]};
`else
  // Natural order: position equals bin.
  assign o_bin = i_pos;
`endif

endmodule

// File: rtl/fft_frame_assembler.sv
// Collects 16 FFT bins from a sample stream into a parallel frame.
// Optional feature macro: FFT_FRAME_BITREV_EN (see frame_idx_map).
// Handshake: a sample transfers on every cycle din_valid is high; there is
// no ready, so the assembler always accepts, and the consumer must capture
// fft_d0..fft_d15 in the single cycle fft_valid is high (they then hold
// until the next completed frame).
module fft_frame_assembler
  import fft_frame_pkg::*;
#(
  parameter int SYNC_ON_SOF = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_valid,
  input  logic             din_sof,
  input  logic [SMP_W-1:0] din,
  output logic [SMP_W-1:0] fft_d0,
  output logic [SMP_W-1:0] fft_d1,
  output logic [SMP_W-1:0] fft_d2,
  output logic [SMP_W-1:0] fft_d3,
  output logic [SMP_W-1:0] fft_d4,
  output logic [SMP_W-1:0] fft_d5,
  output logic [SMP_W-1:0] fft_d6,
  output logic [SMP_W-1:0] fft_d7,
  output logic [SMP_W-1:0] fft_d8,
  output logic [SMP_W-1:0] fft_d9,
  output logic [SMP_W-1:0] fft_d10,
  output logic [SMP_W-1:0] fft_d11,
  output logic [SMP_W-1:0] fft_d12,
  output logic [SMP_W-1:0] fft_d13,
  output logic [SMP_W-1:0] fft_d14,
  output logic [SMP_W-1:0] fft_d15,
  output logic             fft_valid,
  output logic             frame_err,
  output state_t           o_dbg_state
);

  // Free-running mode never waits for a start of frame.
  localparam state_t RST_STATE = (SYNC_ON_SOF != 0) ? IDLE : FILL;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPT - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_wr_idx;
  logic [IDX_W-1:0] w_wr_idx_nxt;
  logic [IDX_W-1:0] w_pos;
  logic [IDX_W-1:0] w_bin;
  logic             w_wr_en;
  logic             w_done;
  logic             w_err;
  logic [SMP_W-1:0] r_col [NPT];
  logic [SMP_W-1:0] r_out [NPT];
  logic             r_fft_valid;
  logic             r_frame_err;

  frame_idx_map u_idx_map (
    .i_pos (w_pos),
    .o_bin (w_bin)
  );

  // Next-state, write position and frame events.
  always_comb begin
    w_state_nxt  = r_state;
    w_wr_idx_nxt = r_wr_idx;
    w_pos        = r_wr_idx;
    w_wr_en      = 1'b0;
    w_done       = 1'b0;
    w_err        = 1'b0;
    if (SYNC_ON_SOF == 0) begin
      // Counter free-runs and wraps after every 16 accepted samples.
      if (din_valid) begin
        w_wr_en      = 1'b1;
        w_wr_idx_nxt = r_wr_idx + IDX_W'(1);
        w_done       = (r_wr_idx == LAST_IDX);
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (din_valid && din_sof) begin
            w_pos        = '0;
            w_wr_en      = 1'b1;
            w_wr_idx_nxt = IDX_W'(1);
            w_state_nxt  = FILL;
          end
        end
        FILL: begin
          if (din_valid) begin
            w_wr_en = 1'b1;
            if (din_sof) begin
              // Restart: drop the partial frame, the new sample is bin 0.
              w_err        = (r_wr_idx != '0);
              w_pos        = '0;
              w_wr_idx_nxt = IDX_W'(1);
            end else if (r_wr_idx == LAST_IDX) begin
              w_done       = 1'b1;
              w_wr_idx_nxt = '0;
              w_state_nxt  = IDLE;
            end else begin
              w_wr_idx_nxt = r_wr_idx + IDX_W'(1);
            end
          end
        end
      endcase
    end
  end

  // State and write counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= RST_STATE;
      r_wr_idx <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_wr_idx <= w_wr_idx_nxt;
    end
  end

  // Collect registers, output frame copy (including the sample completing
  // the frame) and the one-cycle event pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NPT; k++) begin
        r_col[k] <= '0;
        r_out[k] <= '0;
      end
      r_fft_valid <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_col[w_bin] <= din;
      end
      if (w_done) begin
        for (int k = 0; k < NPT; k++) begin
          r_out[k] <= (IDX_W'(k) == w_bin) ? din : r_col[k];
        end
      end
      r_fft_valid <= w_done;
      r_frame_err <= w_err;
    end
  end

  assign fft_valid   = r_fft_valid;
  assign frame_err   = r_frame_err;
  assign o_dbg_state = r_state;
  assign fft_d0  = r_out[0];
  assign fft_d1  = r_out[1];
  assign fft_d2  = r_out[2];
  assign fft_d3  = r_out[3];
  assign fft_d4  = r_out[4];
  assign fft_d5  = r_out[5];
  assign fft_d6  = r_out[6];
  assign fft_d7  = r_out[7];
  assign fft_d8  = r_out[8];
  assign fft_d9  = r_out[9];
  assign fft_d10 = r_out[10];
  assign fft_d11 = r_out[11];
  assign fft_d12 = r_out[12];
  assign fft_d13 = r_out[13];
  assign fft_d14 = r_out[14];
  assign fft_d15 = r_out[15];

endmodule

// File: doc/fft_frame_assembler.md
FFT_FRAME_ASSEMBLER -- requirements
Module: fft_frame_assembler

Interface
REQ-001 SHALL have parameter SYNC_ON_SOF, default 1; 1 = frame filling starts only on din_sof, 0 = filling starts immediately after reset and the counter free-runs.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port din_valid, input, 1 bit: a sample is presented this cycle.
REQ-005 SHALL have port din_sof, input, 1 bit: start of frame, qualified by din_valid.
REQ-006 SHALL have port din, input, 32 bits: one FFT bin, {re[15:0], im[15:0]}, both two's complement.
REQ-007 SHALL have ports fft_d0 .. fft_d15, output, 32 bits each: the assembled frame, bin k on fft_dk, in the same {re, im} format.
REQ-008 SHALL have port fft_valid, output, 1 bit: one-cycle pulse when a new frame appears on fft_d0..fft_d15.
REQ-009 SHALL have port frame_err, output, 1 bit: one-cycle pulse when a partial frame is discarded.

Function
REQ-010 SHALL have two states: IDLE (waiting for start of frame) and FILL (collecting samples); a 4-bit write counter wr_idx SHALL track position within the frame.
REQ-011 In IDLE: din_valid & din_sof SHALL store din at index 0, set wr_idx=1 and enter FILL; din_valid without din_sof SHALL be dropped.
REQ-012 In FILL: din_valid & ~din_sof SHALL store din at index wr_idx and increment wr_idx; din_valid low SHALL hold all state (gaps allowed, no timeout).
REQ-013 When the sample at index 15 is accepted, the 16 collect registers SHALL be copied to the output registers in the same edge, fft_valid SHALL be 1 in the following cycle, and the state SHALL return to IDLE (wr_idx=0).
REQ-014 Latency SHALL be exactly 1 cycle from acceptance of the 16th sample to fft_valid high.
REQ-015 fft_d0..fft_d15 SHALL hold their values until the next completed frame; a new frame may start filling in the cycle after completion with no dead cycle.
REQ-016 In FILL with wr_idx != 0: din_valid & din_sof SHALL pulse frame_err for 1 cycle, discard the partial frame, store din at index 0 and set wr_idx=1; no fft_valid SHALL be emitted for the discarded frame.
REQ-017 With SYNC_ON_SOF=0, IDLE SHALL be skipped: reset enters FILL with wr_idx=0, din_sof SHALL be ignored, frame_err SHALL stay 0, and wr_idx SHALL wrap from 15 to 0 on each completed frame.
REQ-018 No backpressure: the downstream stage SHALL sample fft_d* on the fft_valid cycle; there is no ready input.
REQ-019 Data SHALL pass through bit-exact; no arithmetic, rounding or sign change.

Reset
REQ-020 Asserting rst (low) SHALL immediately clear fft_valid=0, frame_err=0, fft_d0..fft_d15=0, the collect registers=0 and wr_idx=0, and set the state to IDLE (or FILL when SYNC_ON_SOF=0).
REQ-021 Reset asserted mid-frame SHALL discard the partial frame without a frame_err pulse; the first edge after release SHALL behave as the first cycle after power-up.

Configuration
REQ-022 Macro FFT_FRAME_BITREV_EN defined: the sample accepted at position p SHALL be written to index bitrev4(p) (e.g. p=1 to bin 8, p=3 to bin 12), matching radix-2 FFT output order.
REQ-023 Macro FFT_FRAME_BITREV_EN undefined: the sample at position p SHALL be written to index p (natural order); no other behaviour differs.

Structure
REQ-024 Shared package fft_frame_pkg SHALL hold: NPT=16, SMP_W=32, HALF_W=16, IDX_W=4, and the state enum {IDLE, FILL}.
REQ-025 One sub-module, frame_idx_map (4-bit position to 4-bit bin index, purely combinational, bit-reverse under FFT_FRAME_BITREV_EN), SHALL be used; all storage stays in the top module.

Verification
REQ-026 Reset release; sof plus 16 consecutive samples 0x00010000 + p -> fft_valid one cycle after the 16th sample, fft_dk = 0x00010000 + k, frame_err=0.
REQ-027 Same frame with din_valid low every other cycle -> identical fft_d*, fft_valid 1 cycle after the 16th accepted sample, and exactly one fft_valid pulse.
REQ-028 Frame of 7 samples, then sof with 0xAAAA5555 followed by 15 samples -> frame_err pulses on the restart edge, then fft_d0=0xAAAA5555 and one fft_valid pulse.
REQ-029 Back-to-back frames with no gap (second sof in the cycle after the first frame's 16th sample) -> two fft_valid pulses 16 cycles apart; fft_d* from frame 1 held until frame 2 completes.
REQ-030 rst pulsed low after 10 samples -> all outputs 0 immediately; a following full frame completes normally with no frame_err.
REQ-031 FFT_FRAME_BITREV_EN defined, positions p=0..15 carrying value p -> fft_d8=1, fft_d12=3, fft_d15=15.
